// File: rtl/fp_accum_seq.sv
// rtl/fp_accum_seq.sv - sequential float accumulator front-end for an external combinational adder
module fp_accum_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_special,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_s
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              spec_q, spec_d;
    logic              accept;
    logic              release_res;

    assign accept      = in_valid & in_ready;
    assign release_res = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (accept && in_last) state_d = ST_DONE;
            ST_DONE:  if (release_res)       state_d = ST_ACCUM;
            default:                         state_d = ST_ACCUM;
        endcase
    end

    // Handshake depends on state alone, so out_ready never reaches in_ready combinationally.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_ACCUM: in_ready  = 1'b1;
            ST_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        spec_d = spec_q;
        if (accept) begin
            acc_d  = add_s;
            cnt_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
            spec_d = spec_q | (in_data[30:23] == 8'hFF);
        end else if (release_res) begin
            acc_d  = 32'h0000_0000;
            cnt_d  = '0;
            spec_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= 32'h0000_0000;
            cnt_q  <= '0;
            spec_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            spec_q <= spec_d;
        end
    end

    assign add_a       = acc_q;
    assign add_b       = in_data;
    assign out_sum     = acc_q;
    assign out_count   = cnt_q;
    assign out_special = spec_q;

endmodule

// File: tb/tb_fp_accum_seq.sv
// tb/tb_fp_accum_seq.sv - directed bench for fp_accum_seq with a table-driven adder model
module tb_fp_accum_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_valid2;
    logic        in_ready, in_ready2;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [31:0] out_sum, out_sum2;
    logic [15:0] out_count;
    logic [1:0]  out_count2;
    logic        out_special, out_special2;
    logic [31:0] add_a, add_b, add_s;
    logic [31:0] add_a2, add_b2, add_s2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Exact sums for the operand pairs used below; zero is the additive identity.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'h0) return b;
        if (b[30:0] == 31'h0) return a;
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h40400000, 32'h3F000000}: return 32'h40600000;
            {32'h3F800000, 32'hBF800000}: return 32'h00000000;
            {32'h7F800000, 32'h3F800000}: return 32'h7F800000;
            default:                      return 32'h7FC00000;
        endcase
    endfunction

    assign add_s  = fadd(add_a, add_b);
    assign add_s2 = fadd(add_a2, add_b2);

    fp_accum_seq #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .out_special(out_special),
        .add_a(add_a), .add_b(add_b), .add_s(add_s)
    );

    fp_accum_seq #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
        .out_count(out_count2), .out_special(out_special2),
        .add_a(add_a2), .add_b(add_b2), .add_s(add_s2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        chk("push_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic finish_vec(input string tag, input logic [31:0] sum, input int cnt, input logic spec);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_sum"}, out_sum, sum);
        chk({tag, "_count"}, 32'(out_count), 32'(cnt));
        chk({tag, "_special"}, 32'(out_special), 32'(spec));
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_idle_acc"}, out_sum, 32'h0);
        chk({tag, "_idle_cnt"}, 32'(out_count), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        in_data   = 32'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", out_sum, 32'h0);
        chk("reset_count", 32'(out_count), 32'd0);
        chk("reset_special", 32'(out_special), 32'd0);

        // 1.0 + 2.0 + 0.5, with a non-accepted garbage cycle in between
        push(32'h3F800000, 1'b0);
        @(negedge clk);
        chk("add_a_is_acc", add_a, 32'h3F800000);
        chk("add_b_is_data", add_b, in_data);
        in_valid = 1'b0;
        in_data  = 32'hFFFFFFFF;
        in_last  = 1'b1;
        @(negedge clk);
        chk("gap_hold_count", 32'(out_count), 32'd1);
        chk("gap_hold_acc", out_sum, 32'h3F800000);
        chk("gap_no_done", 32'(out_valid), 32'd0);
        push(32'h40000000, 1'b0);
        push(32'h3F000000, 1'b1);
        finish_vec("v3", 32'h40600000, 3, 1'b0);
        expect_idle("v3");

        push(32'h40400000, 1'b1);
        finish_vec("single", 32'h40400000, 1, 1'b0);
        expect_idle("single");

        push(32'h3F800000, 1'b0);
        push(32'hBF800000, 1'b1);
        finish_vec("cancel", 32'h00000000, 2, 1'b0);
        expect_idle("cancel");

        out_ready = 1'b0;
        push(32'h40000000, 1'b1);
        finish_vec("bp", 32'h40000000, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_sum", out_sum, 32'h40000000);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        expect_idle("bp");

        push(32'h7F800000, 1'b0);
        push(32'h3F800000, 1'b1);
        finish_vec("inf", 32'h7F800000, 2, 1'b1);
        expect_idle("inf");
        push(32'h3F800000, 1'b1);
        finish_vec("after_inf", 32'h3F800000, 1, 1'b0);
        expect_idle("after_inf");

        // Reset mid-vector discards the partial sum
        push(32'h40000000, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_count", 32'(out_count), 32'd0);
        push(32'h3F800000, 1'b1);
        finish_vec("midrst", 32'h3F800000, 1, 1'b0);
        expect_idle("midrst");

        // Reset while a result is pending
        out_ready = 1'b0;
        push(32'h40400000, 1'b1);
        finish_vec("donerst", 32'h40400000, 1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        chk("donerst_valid", 32'(out_valid), 32'd0);
        chk("donerst_ready", 32'(in_ready), 32'd1);
        chk("donerst_count", 32'(out_count), 32'd0);

        // Counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid2 = 1'b1;
            in_data   = 32'h0;
            in_last   = (i == 4);
            chk("sat_in_ready", 32'(in_ready2), 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid2 = 1'b0;
        chk("sat_valid", 32'(out_valid2), 32'd1);
        chk("sat_count", 32'(out_count2), 32'd3);
        chk("sat_sum", out_sum2, 32'h0);
        chk("sat_special", 32'(out_special2), 32'd0);
        chk("sat_other_idle", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
